gate_truth_sequencer: RTL

//   Self-checking sequencer for an N_IN-input combinational gate (default: 2-input NOR).
//   On start: drives every input vector 0..2^N_IN-1 in ascending order, holds each for

---
 rtl/gate_truth_sequencer_if.sv | 24 ++
 rtl/gate_truth_sequencer.sv | 120 ++++++++++++
 2 files changed

// File: rtl/gate_truth_sequencer_if.sv
// Handshake/status bundle between a BIST controller, the gate under test and gate_truth_sequencer.
// The sequencer side uses the slave modport; the controller/gate side uses master.
interface gate_truth_sequencer_if #(
    parameter int N_IN = 2
);
    logic                   start;
    logic                   gate_y;
    logic [N_IN-1:0]        drv;
    logic                   busy;
    logic                   done;
    logic                   pass;
    logic [N_IN:0]          err_count;
    logic [(1<<N_IN)-1:0]   fail_vec;

    modport master (
        output start, gate_y,
        input  drv, busy, done, pass, err_count, fail_vec
    );

    modport slave (
        input  start, gate_y,
        output drv, busy, done, pass, err_count, fail_vec
    );
endinterface

// File: rtl/gate_truth_sequencer.sv
// Exhaustive truth-table checker for an N_IN-input combinational gate.
// Optional GATE_SEQ_STOP_ON_FAIL_EN: end the run on the first mismatching vector.
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | driving vector drv, settle down-counter running, sample at terminal count
// DONE  | results valid and held; start begins a new run
module gate_truth_sequencer #(
    parameter int                  N_IN       = 2,
    parameter int                  SETTLE_CYC = 2,
    parameter logic [(1<<N_IN)-1:0] TRUTH     = 4'b0001
) (
    input  logic                    clk,
    input  logic                    rst_n,
    gate_truth_sequencer_if.slave   bus
);
    localparam int NV    = 1 << N_IN;
    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [N_IN-1:0]   drv_q, drv_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [N_IN:0]     err_q, err_d;
    logic [NV-1:0]     fail_q, fail_d;
    logic              mismatch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            drv_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fail_q  <= '0;
        end else begin
            state_q <= state_d;
            drv_q   <= drv_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
        end
    end

    // Case inequality so an X/Z gate output is scored as a mismatch in simulation.
    assign mismatch = (bus.gate_y !== TRUTH[drv_q]);

    always_comb begin
        state_d = state_q;
        drv_d   = drv_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        err_d   = err_q;
        fail_d  = fail_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = RUN;
                    drv_d   = '0;
                    cnt_d   = CNT_W'(SETTLE_CYC - 1);
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    err_d   = '0;
                    fail_d  = '0;
                end
            end
            RUN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    if (mismatch) begin
                        fail_d[drv_q] = 1'b1;
                        err_d         = err_q + (N_IN+1)'(1);
                    end
`ifdef GATE_SEQ_STOP_ON_FAIL_EN
                    if (mismatch) begin
                        // drv keeps the failing vector for post-mortem probing
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = 1'b0;
                    end else if (drv_q == N_IN'(NV - 1)) begin
`else
                    if (drv_q == N_IN'(NV - 1)) begin
`endif
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                        drv_d   = '0;
                    end else begin
                        drv_d = drv_q + N_IN'(1);
                        cnt_d = CNT_W'(SETTLE_CYC - 1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.drv       = drv_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.err_count = err_q;
    assign bus.fail_vec  = fail_q;
endmodule
